fifo_write_arbiter: RTL and testbench

//   Round-robin arbiter sharing the fifo write port between NREQ requesters.

---
 rtl/fifo_write_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one fifo write port between NREQ requesters.
// A grant lasts for at most BURSTLEN accepted words. While the fifo is full
// the grant stalls and keeps its place. Each word is consumed exactly once,
// in a cycle where signal_write is high.
module fifo_write_arbiter #(
    parameter int WORDSIZE = 8,
    parameter int NREQ     = 4,
    parameter int BURSTLEN = 4
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORDSIZE-1:0] req_data,
    input  logic                     full,
    output logic [NREQ-1:0]          grant,
    output logic [WORDSIZE-1:0]      write_data,
    output logic                     signal_write,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(BURSTLEN) + 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(BURSTLEN - 1);
    localparam logic [OW-1:0] LAST_RST  = OW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [OW-1:0]   last;
    logic [BW-1:0]   bcnt;

    logic            accept;
    logic            exhausted;
    logic            release_now;
    logic [NREQ-1:0] cand;
    logic [OW-1:0]   search_after;
    logic [OW-1:0]   next_owner;

    // Returns the first index after 'after' (wrapping mod NREQ) whose bit is
    // set in c. The scan runs from the farthest candidate down to the nearest,
    // so the nearest one is written last and wins. NREQ need not be a power of 2.
    function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] c,
                                           input logic [OW-1:0]   after);
        logic [OW-1:0] r;
        int            idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(after) + k) % NREQ;
            if (c[idx]) r = OW'(idx);
        end
        return r;
    endfunction

    // Accept, release and next-owner decode for the current cycle.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        accept       = (state == GRANT) && req[owner] && !full;
        exhausted    = accept && (bcnt == BCNT_LAST);
        release_now  = (state == GRANT) && (exhausted || !req[owner]);
        cand         = req;
        if (exhausted) cand[owner] = 1'b0;
        // The search starts after the owner being released, or after 'last' when idle.
        search_after = (state == GRANT) ? owner : last;
        next_owner   = pick(cand, search_after);
    end

    // Write-port outputs are driven only in GRANT; otherwise they are zero.
    always_comb begin
        signal_write = accept;
        write_data   = '0;
        if (state == GRANT) write_data = req_data[owner*WORDSIZE +: WORDSIZE];
    end

    // Arbitration state: grant, owner, round-robin pointer and burst count.
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            last  <= LAST_RST;
            bcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        owner <= next_owner;
                        grant <= NREQ'(1) << next_owner;
                        bcnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last <= owner;
                        bcnt <= '0;
                        if (|cand) begin
                            owner <= next_owner;
                            grant <= NREQ'(1) << next_owner;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (accept) begin
                        bcnt <= bcnt + 1'b1;
                    end
                    // When req[owner] is high and full is high, everything holds.
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter. It applies table vectors,
// directed corner sequences and a randomized scoreboard run. Every cycle is
// compared against a behavioural round-robin model.
module tb_fifo_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int BL = 4;

    logic           wclk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           full;
    logic [N-1:0]   grant;
    logic [W-1:0]   write_data;
    logic           signal_write;
    logic [1:0]     owner;

    logic [W-1:0]   data [N];

    int tests  = 0;
    int failed = 0;

    // Behavioural model: whether a grant is held, who holds it, how many words
    // it has used, and the last releaser.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_words = 0;

    fifo_write_arbiter #(.WORDSIZE(W), .NREQ(N), .BURSTLEN(BL)) dut (
        .wclk(wclk), .rst(rst), .req(req), .req_data(req_data), .full(full),
        .grant(grant), .write_data(write_data), .signal_write(signal_write),
        .owner(owner)
    );

    always #5 wclk = ~wclk;

    // Pack the per-port words onto the flat data bus.
    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*W +: W] = data[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester after 'from', wrapping around the ring.
    function automatic int rr_next(input logic [N-1:0] c, input int from);
        for (int i = 1; i <= N; i++)
            if (c[(from + i) % N]) return (from + i) % N;
        return -1;
    endfunction

    task automatic check_model();
        logic [N-1:0] eg;
        bit           esw;
        logic [W-1:0] ewd;
        eg  = m_busy ? N'(1 << m_owner) : '0;
        esw = m_busy && req[m_owner] && !full;
        ewd = m_busy ? data[m_owner] : '0;
        check("model_grant", grant, eg);
        check("model_write", signal_write, esw);
        check("model_wdata", write_data, ewd);
        if (m_busy) check("model_owner", owner, m_owner);
        check("onehot", ($countones(grant) <= 1), 1);
        check("no_write_when_full", signal_write && full, 0);
    endtask

    task automatic model_step();
        logic [N-1:0] c;
        bit           acc;
        bit           rel;
        bit           excl;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0;
            return;
        end
        acc = m_busy && req[m_owner] && !full;
        rel = 0; excl = 0;
        if (!m_busy) begin
            if (req != 0) begin
                m_owner = rr_next(req, m_last);
                m_busy  = 1;
                m_words = 0;
            end
        end else if (acc) begin
            m_words++;
            if (m_words == BL) begin rel = 1; excl = 1; end
        end else if (!req[m_owner]) begin
            rel = 1;
        end
        if (rel) begin
            m_last = m_owner;
            c = req;
            if (excl) c[m_owner] = 1'b0;
            m_words = 0;
            if (c != 0) m_owner = rr_next(c, m_last);
            else        m_busy = 0;
        end
    endtask

    task automatic at_neg();
        @(negedge wclk);
    endtask

    task automatic tick_rest();
        check_model();
        model_step();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; full = 1'b0;
        at_neg();
        tick_rest();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] grant;
        logic         sw;
        logic [W-1:0] wd;
    } vec_t;

    vec_t vecs [7];

    logic [W-1:0] exp_q [N][$];
    bit           valid    [N];
    bit           consumed [N];

    initial begin
        rst = 1'b1; req = '0; full = 1'b0;
        for (int i = 0; i < N; i++) data[i] = '0;

        // Sole requester: grant, burst of 4, one idle bubble, then a new grant.
        vecs[0] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5};
        vecs[2] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5};
        vecs[3] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5};
        vecs[4] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5};
        vecs[5] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[6] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5};

        apply_reset();
        at_neg();
        check("reset_grant", grant, 0);
        check("reset_write", signal_write, 0);
        check("reset_wdata", write_data, 0);
        tick_rest();

        data[0] = 8'hA5;
        foreach (vecs[v]) begin
            req = vecs[v].req; full = vecs[v].full;
            at_neg();
            check($sformatf("vec%0d_grant", v), grant, vecs[v].grant);
            check($sformatf("vec%0d_write", v), signal_write, vecs[v].sw);
            check($sformatf("vec%0d_wdata", v), write_data, vecs[v].wd);
            tick_rest();
        end

        // All four requesting: owners 0,1,2,3,0 in back-to-back bursts of 4.
        apply_reset();
        for (int i = 0; i < N; i++) data[i] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int c = 0; c <= 20; c++) begin
            at_neg();
            if (c == 0) check("t2_first_idle", signal_write, 0);
            else begin
                check("t2_write", signal_write, 1);
                check("t2_owner", owner, ((c - 1) / BL) % N);
            end
            tick_rest();
        end

        // Owner 1 stalls on full at bcnt=2, then finishes 2 words and rotates.
        apply_reset();
        data[1] = 8'h31; data[0] = 8'h07;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin at_neg(); tick_rest(); end
        req = 4'b0011; full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            check("t3_hold_grant", grant, 4'b0010);
            check("t3_hold_write", signal_write, 0);
            tick_rest();
        end
        full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            check("t3_tail_write", signal_write, 1);
            check("t3_tail_grant", grant, 4'b0010);
            tick_rest();
        end
        at_neg();
        check("t3_rotate", grant, 4'b0001);
        tick_rest();

        // Owner 2 drops req after one write; port 0 takes over with no write from port 2.
        apply_reset();
        data[2] = 8'h42;
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin at_neg(); tick_rest(); end
        req = 4'b0001;
        at_neg();
        check("t4_drop_nowrite", signal_write, 0);
        tick_rest();
        at_neg();
        check("t4_regrant", grant, 4'b0001);
        check("t4_first_write", signal_write, 1);
        tick_rest();

        // A reset pulse in the middle of owner 3's burst.
        apply_reset();
        data[3] = 8'h53;
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin at_neg(); tick_rest(); end
        rst = 1'b1; full = 1'b1; req = 4'b1001;
        at_neg();
        tick_rest();
        rst = 1'b0; full = 1'b0;
        at_neg();
        check("t5_grant_dropped", grant, 0);
        check("t5_no_write", signal_write, 0);
        tick_rest();
        at_neg();
        check("t5_regrant_port0", grant, 4'b0001);
        tick_rest();

        // Random traffic. Each port holds its word until it is written; the
        // scoreboard checks order and catches loss or duplication.
        apply_reset();
        for (int i = 0; i < N; i++) begin valid[i] = 0; consumed[i] = 0; end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (consumed[i]) valid[i] = 0;
                consumed[i] = 0;
                if (!valid[i] && $urandom_range(0, 99) < 55) begin
                    valid[i] = 1;
                    data[i]  = 8'($urandom);
                    exp_q[i].push_back(data[i]);
                end
                req[i] = valid[i];
            end
            full = ($urandom_range(0, 99) < 25);
            at_neg();
            if (signal_write) begin
                int p;
                p = int'(owner);
                consumed[p] = 1;
                if (exp_q[p].size() == 0) begin
                    tests++; failed++;
                    $display("FAIL sb_dup: port %0d wrote %0h, expected no pending word", p, write_data);
                end else begin
                    check("sb_data", write_data, exp_q[p].pop_front());
                end
            end
            tick_rest();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("sb_loss_port%0d", i), exp_q[i].size(), (valid[i] && !consumed[i]) ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
